// File: rtl/count_chk_pkg.sv
// Shared types and constants for the count_checker monitor and its predictor.
// Optional first-error capture in count_checker is enabled by COUNT_CHK_FIRST_ERR_EN.
package count_chk_pkg;

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

   localparam int unsigned ERR_SEQ_BIT  = 0;
   localparam int unsigned ERR_ZERO_BIT = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } chk_state_e;

endpackage

// File: rtl/count_chk_predict.sv
// Next visible counter value, given the visible value and the load strobe seen one edge earlier.
// Shared with the bench scoreboard; independent of COUNT_CHK_FIRST_ERR_EN.
module count_chk_predict
   import count_chk_pkg::*;
(
   input  logic [CNT_W-1:0] number,
   input  logic             set_d1,
   input  logic [CNT_W-1:0] set_num_d1,
   output logic [CNT_W-1:0] exp_next
);

   // A wrap out of 15 wins over a pending load.
   always_comb begin
      exp_next = number + CNT_W'(1);
      if (number == CNT_MAX) begin
         exp_next = '0;
      end else if (set_d1) begin
         exp_next = set_num_d1;
      end
   end

endmodule

// File: rtl/count_checker.sv
// In-line monitor for the 4-bit loadable wrap counter: checks number/zero, counts wraps and errors.
// Define COUNT_CHK_FIRST_ERR_EN to add first-mismatch capture outputs.
module count_checker
   import count_chk_pkg::*;
#(
   parameter int unsigned ERR_W  = 8,
   parameter int unsigned WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chk_en,
   input  logic              set,
   input  logic [CNT_W-1:0]  set_num,
   input  logic [CNT_W-1:0]  number,
   input  logic              zero,
   output logic              locked,
   output logic              err_pulse,
   output logic [1:0]        err_code,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [WRAP_W-1:0] wrap_cnt
`ifdef COUNT_CHK_FIRST_ERR_EN
   ,
   output logic              first_err_valid,
   output logic [CNT_W-1:0]  first_exp,
   output logic [CNT_W-1:0]  first_obs
`endif
);

   chk_state_e        state_q, state_d;
   logic [CNT_W-1:0]  exp_q, exp_d;
   logic              set_d1_q;
   logic [CNT_W-1:0]  set_num_d1_q;
   logic [CNT_W-1:0]  prev_num_q;
   logic              prev_valid_q;
   logic              err_pulse_q, err_pulse_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

   logic              compare_en;
   logic              seq_err;
   logic              zero_err;
   logic              mismatch;

   count_chk_predict u_predict (
      .number     (number),
      .set_d1     (set_d1_q),
      .set_num_d1 (set_num_d1_q),
      .exp_next   (exp_d)
   );

   // Dropping chk_en while tracking suppresses the check on that same edge.
   always_comb begin
      state_d     = chk_en ? TRACK : IDLE;
      compare_en  = (state_q == TRACK) && chk_en;
      seq_err     = (number != exp_q);
      zero_err    = (zero != (number == '0));
      mismatch    = compare_en && (seq_err || zero_err);
      err_pulse_d = mismatch;
      err_code_d  = err_code_q;
      err_cnt_d   = err_cnt_q;
      wrap_cnt_d  = wrap_cnt_q;

      if (mismatch) begin
         err_code_d[ERR_SEQ_BIT]  = seq_err;
         err_code_d[ERR_ZERO_BIT] = zero_err;
         if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end

      if (compare_en && prev_valid_q && (prev_num_q == CNT_MAX) && (number == '0)) begin
         wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         exp_q        <= '0;
         set_d1_q     <= 1'b0;
         set_num_d1_q <= '0;
         prev_num_q   <= '0;
         prev_valid_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_code_q   <= '0;
         err_cnt_q    <= '0;
         wrap_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         set_d1_q     <= set;
         set_num_d1_q <= set_num;
         prev_num_q   <= number;
         prev_valid_q <= chk_en;
         err_pulse_q  <= err_pulse_d;
         err_code_q   <= err_code_d;
         err_cnt_q    <= err_cnt_d;
         wrap_cnt_q   <= wrap_cnt_d;
      end
   end

   assign locked    = (state_q == TRACK);
   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;
   assign err_cnt   = err_cnt_q;
   assign wrap_cnt  = wrap_cnt_q;

`ifdef COUNT_CHK_FIRST_ERR_EN
   logic             first_valid_q;
   logic [CNT_W-1:0] first_exp_q;
   logic [CNT_W-1:0] first_obs_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_valid_q <= 1'b0;
         first_exp_q   <= '0;
         first_obs_q   <= '0;
      end else if (mismatch && !first_valid_q) begin
         first_valid_q <= 1'b1;
         first_exp_q   <= exp_q;
         first_obs_q   <= number;
      end
   end

   assign first_err_valid = first_valid_q;
   assign first_exp       = first_exp_q;
   assign first_obs       = first_obs_q;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: free-run, load/wrap timing, injected faults, saturation, reset.
module tb_count_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       chk_en;
   logic       set;
   logic [3:0] set_num;
   logic [3:0] number;
   logic       zero;

   logic       locked, err_pulse;
   logic [1:0] err_code;
   logic [7:0] err_cnt, wrap_cnt;

   logic       s_locked, s_err_pulse;
   logic [1:0] s_err_code;
   logic [1:0] s_err_cnt;
   logic [7:0] s_wrap_cnt;

   int errors = 0;
   int checks = 0;

`ifdef COUNT_CHK_FIRST_ERR_EN
   logic       fev, s_fev;
   logic [3:0] fexp, fobs, s_fexp, s_fobs;
`endif

   count_checker #(.ERR_W(8), .WRAP_W(8)) dut (
      .clk(clk), .rst(rst), .chk_en(chk_en), .set(set), .set_num(set_num),
      .number(number), .zero(zero), .locked(locked), .err_pulse(err_pulse),
      .err_code(err_code), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
`ifdef COUNT_CHK_FIRST_ERR_EN
      , .first_err_valid(fev), .first_exp(fexp), .first_obs(fobs)
`endif
   );

   count_checker #(.ERR_W(2), .WRAP_W(8)) u_sat (
      .clk(clk), .rst(rst), .chk_en(chk_en), .set(set), .set_num(set_num),
      .number(number), .zero(zero), .locked(s_locked), .err_pulse(s_err_pulse),
      .err_code(s_err_code), .err_cnt(s_err_cnt), .wrap_cnt(s_wrap_cnt)
`ifdef COUNT_CHK_FIRST_ERR_EN
      , .first_err_valid(s_fev), .first_exp(s_fexp), .first_obs(s_fobs)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       s;
      logic [3:0] sn;
      logic [3:0] num;
      logic       z;
      logic       ep;
      logic [1:0] code;
      logic [7:0] cnt;
      logic [7:0] wrap;
      logic       lk;
      logic [1:0] sat;
   } vec_t;

   vec_t tbl[30];

   function automatic vec_t mk(input int en, s, sn, num, z, ep, code, cnt, wrap, lk, sat);
      vec_t v;
      v.en = 1'(en);  v.s = 1'(s);  v.sn = 4'(sn);  v.num = 4'(num);  v.z = 1'(z);
      v.ep = 1'(ep);  v.code = 2'(code);  v.cnt = 8'(cnt);  v.wrap = 8'(wrap);
      v.lk = 1'(lk);  v.sat = 2'(sat);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic en, input logic s, input logic [3:0] sn,
                       input logic [3:0] n, input logic z);
      @(negedge clk);
      chk_en = en; set = s; set_num = sn; number = n; zero = z;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          en s sn num z | ep code cnt wrap lk sat
      tbl[0]  = mk(1, 1, 9,  4, 0,  0, 0, 0, 2, 1, 0);
      tbl[1]  = mk(1, 0, 0,  5, 0,  0, 0, 0, 2, 1, 0);
      tbl[2]  = mk(1, 0, 0,  9, 0,  0, 0, 0, 2, 1, 0);
      tbl[3]  = mk(1, 0, 0, 10, 0,  0, 0, 0, 2, 1, 0);
      tbl[4]  = mk(1, 0, 0, 11, 0,  0, 0, 0, 2, 1, 0);
      tbl[5]  = mk(1, 0, 0, 12, 0,  0, 0, 0, 2, 1, 0);
      tbl[6]  = mk(1, 0, 0, 13, 0,  0, 0, 0, 2, 1, 0);
      tbl[7]  = mk(1, 1, 7, 14, 0,  0, 0, 0, 2, 1, 0);
      tbl[8]  = mk(1, 0, 0, 15, 0,  0, 0, 0, 2, 1, 0);
      tbl[9]  = mk(1, 0, 0,  0, 1,  0, 0, 0, 3, 1, 0);
      tbl[10] = mk(1, 1, 14, 1, 0,  0, 0, 0, 3, 1, 0);
      tbl[11] = mk(1, 0, 0,  2, 0,  0, 0, 0, 3, 1, 0);
      tbl[12] = mk(1, 1, 7, 14, 0,  0, 0, 0, 3, 1, 0);
      tbl[13] = mk(1, 0, 0, 15, 0,  0, 0, 0, 3, 1, 0);
      tbl[14] = mk(1, 0, 0,  7, 0,  1, 1, 1, 3, 1, 1);
      tbl[15] = mk(1, 0, 0,  8, 0,  0, 1, 1, 3, 1, 1);
      tbl[16] = mk(1, 0, 0, 10, 0,  1, 1, 2, 3, 1, 2);
      tbl[17] = mk(1, 0, 0, 11, 0,  0, 1, 2, 3, 1, 2);
      tbl[18] = mk(1, 0, 0, 12, 1,  1, 2, 3, 3, 1, 3);
      tbl[19] = mk(1, 0, 0, 13, 0,  0, 2, 3, 3, 1, 3);
      tbl[20] = mk(1, 0, 0, 14, 0,  0, 2, 3, 3, 1, 3);
      tbl[21] = mk(1, 0, 0, 15, 0,  0, 2, 3, 3, 1, 3);
      tbl[22] = mk(1, 0, 0,  0, 0,  1, 2, 4, 4, 1, 3);
      tbl[23] = mk(1, 0, 0,  1, 0,  0, 2, 4, 4, 1, 3);
      tbl[24] = mk(1, 0, 0,  0, 0,  1, 3, 5, 4, 1, 3);
      tbl[25] = mk(1, 0, 0,  1, 0,  0, 3, 5, 4, 1, 3);
      tbl[26] = mk(0, 0, 0,  5, 0,  0, 3, 5, 4, 0, 3);
      tbl[27] = mk(0, 0, 0,  0, 0,  0, 3, 5, 4, 0, 3);
      tbl[28] = mk(1, 0, 0,  0, 1,  0, 3, 5, 4, 1, 3);
      tbl[29] = mk(1, 0, 0,  1, 0,  0, 3, 5, 4, 1, 3);

      rst = 1'b1; chk_en = 1'b0; set = 1'b0; set_num = '0; number = '0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_pulse", int'(err_pulse), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_wrap_cnt", int'(wrap_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      // Free-running counter 0..15,0..15,0..3
      for (int i = 0; i < 36; i++) begin
         step(1'b1, 1'b0, 4'd0, 4'(i % 16), (i % 16) == 0);
         chk("free_locked", int'(locked), 1);
         chk("free_err_pulse", int'(err_pulse), 0);
         chk("free_err_cnt", int'(err_cnt), 0);
         chk("free_wrap_cnt", int'(wrap_cnt), (i >= 16 ? 1 : 0) + (i >= 32 ? 1 : 0));
      end

      for (int i = 0; i < 30; i++) begin
         step(tbl[i].en, tbl[i].s, tbl[i].sn, tbl[i].num, tbl[i].z);
         chk($sformatf("vec%0d_err_pulse", i), int'(err_pulse), int'(tbl[i].ep));
         chk($sformatf("vec%0d_err_code", i), int'(err_code), int'(tbl[i].code));
         chk($sformatf("vec%0d_err_cnt", i), int'(err_cnt), int'(tbl[i].cnt));
         chk($sformatf("vec%0d_wrap_cnt", i), int'(wrap_cnt), int'(tbl[i].wrap));
         chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].lk));
         chk($sformatf("vec%0d_sat_cnt", i), int'(s_err_cnt), int'(tbl[i].sat));
      end

`ifdef COUNT_CHK_FIRST_ERR_EN
      chk("first_valid", int'(fev), 1);
      chk("first_exp", int'(fexp), 0);
      chk("first_obs", int'(fobs), 7);
`endif

      // Asynchronous reset in the middle of a cycle
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_locked", int'(locked), 0);
      chk("mid_rst_err_code", int'(err_code), 0);
      chk("mid_rst_err_cnt", int'(err_cnt), 0);
      chk("mid_rst_wrap_cnt", int'(wrap_cnt), 0);
      chk("mid_rst_sat_cnt", int'(s_err_cnt), 0);
`ifdef COUNT_CHK_FIRST_ERR_EN
      chk("mid_rst_first_valid", int'(fev), 0);
`endif
      @(negedge clk);
      rst = 1'b0; chk_en = 1'b1; set = 1'b0; number = 4'd0; zero = 1'b1;
      #1;
      chk("post_rst_unlocked", int'(locked), 0);
      @(posedge clk);
      #1;
      chk("post_rst_locked", int'(locked), 1);
      chk("post_rst_err_pulse", int'(err_pulse), 0);
      step(1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
      chk("post_rst_track_pulse", int'(err_pulse), 0);
      step(1'b1, 1'b0, 4'd0, 4'd5, 1'b0);
      chk("post_rst_inj_pulse", int'(err_pulse), 1);
      chk("post_rst_inj_code", int'(err_code), 1);
      chk("post_rst_inj_cnt", int'(err_cnt), 1);
`ifdef COUNT_CHK_FIRST_ERR_EN
      chk("post_rst_first_exp", int'(fexp), 2);
      chk("post_rst_first_obs", int'(fobs), 5);
`endif
      step(1'b1, 1'b0, 4'd0, 4'd6, 1'b0);
      chk("post_rst_resync_pulse", int'(err_pulse), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Receiving-end monitor for the 4-bit loadable wrap counter's registered outputs (`number`, `zero`).
- Taps the same `set`/`set_num` the counter sees. Predicts the next `number` each cycle and checks both `number` and the `zero` flag.
- Counts wraps and errors, and raises a one-cycle error pulse on any mismatch.
- Sits beside the counter in the system and in benches as an in-line protocol checker.

Parameters:
- ERR_W, 8, width of saturating error counter
- WRAP_W, 8, width of wrapping 15->0 transition counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- chk_en  in  1  checking enable; low forces IDLE
- set  in  1  same load strobe driven to the counter
- set_num  in  4  same load value driven to the counter
- number  in  4  counter's registered count output
- zero  in  1  counter's registered zero flag
- locked  out  1  high while in TRACK
- err_pulse  out  1  one-cycle pulse per detected mismatch
- err_code  out  2  bit0 = sequence error, bit1 = zero-flag error; valid with err_pulse, held until next error
- err_cnt  out  ERR_W  saturating mismatch count
- wrap_cnt  out  WRAP_W  count of observed 15->0 transitions, wraps modulo 2^WRAP_W

Behaviour:
- Reset is asynchronous, active-high. All outputs and state reset to 0: state=IDLE, exp=0, set_d1=0, set_num_d1=0, prev_valid=0.
- Reset asserted mid-operation aborts tracking immediately. The first post-reset cycle is treated as a fresh lock.
- Counter timing the checker models:
  - The counter's `number` lags its internal count by one cycle.
  - A `set` sampled at edge e_t affects `number` visible after e_{t+2}.
  - The checker registers `set`/`set_num` into `set_d1`/`set_num_d1` every edge, regardless of state.
- Prediction, computed every edge from the currently visible `number`:
  - exp <= (number==15) ? 0 : (set_d1 ? set_num_d1 : number+1), 4-bit arithmetic.
  - Wrap has priority over load: number==15 with set_d1=1 predicts 0.
- States:
  - IDLE: no checking. If chk_en=1, load exp per the rule and go to TRACK next edge. locked=0.
  - TRACK: each edge, compare visible `number` against exp and `zero` against (number==0).
    - Any mismatch: err_pulse=1 next cycle, err_code updated, err_cnt+1 (saturates at all-ones).
    - exp always reloads from the observed number (self-resync), so one corrupted sample yields one error.
    - chk_en=0 -> IDLE next edge; err_pulse stays 0 from that edge on.
- Sequence and zero errors in the same cycle: single pulse, err_code=2'b11, err_cnt increments by 1.
- wrap_cnt increments in TRACK when the previous sample was 15 and the current sample is 0.
- Latency: mismatching sample visible in cycle c -> err_pulse high in cycle c+1.
- Counter-reset artifact (number=0, zero=0 during counter reset) is not checked while the checker is in IDLE.

Optional Feature:
- COUNT_CHK_FIRST_ERR_EN
- When defined:
  - adds outputs first_err_valid (1), first_exp (4), first_obs (4);
  - the first mismatch after reset captures exp and the observed number, and sets first_err_valid;
  - all three hold until rst;
  - later errors do not overwrite them.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package count_chk_pkg holds:
  - state enum {IDLE, TRACK};
  - err_code bit-position constants (ERR_SEQ_BIT=0, ERR_ZERO_BIT=1);
  - CNT_W=4 and CNT_MAX=15.
- One sub-module, count_chk_predict: purely combinational next-value function (number, set_d1, set_num_d1 -> exp_next). It is reused by the bench scoreboard.

Test Plan:
- Free-run after rst release with chk_en=1, counter 0..15..0 for 40 cycles -> locked=1 from cycle 2, err_cnt=0, wrap_cnt=2 after second 15->0.
- set=1 with set_num=9 for one cycle while counter is at 4 -> number 4,5,9,10 observed; no err_pulse.
- set=1 with set_num=7 when the set lands with number=15 -> next number 0 expected; counter shows 0 -> no error. Forcing 7 instead -> err_pulse, err_code=2'b01.
- Inject number=6 where 5 expected, zero correct -> exactly one err_pulse, err_code=01, err_cnt=1. Next sample 7 -> no further error.
- Inject zero=1 with number=3 -> err_pulse, err_code=2'b10. Inject number=0 with zero=0 where 0 expected -> err_code=2'b10.
- With ERR_W=2, inject 5 errors -> err_cnt=3 saturated. Assert rst mid-stream -> all outputs 0, locked returns 1 one cycle after release. With COUNT_CHK_FIRST_ERR_EN defined, first_exp/first_obs hold the first injection's values.
